muldiv_unit: RTL and testbench

- Parametrised, iterative multiply/divide engine with architectural HI/LO registers for the MIPS core.
- Replaces the separate single-purpose Mul/Multu/Div/Divu blocks and the two ad hoc HI/LO registers with one unit.
- Executes MULTU, MULT, DIVU and DIV with a start/busy/done handshake; the controller stalls the PC while busy is high.
- Also services MTHI/MTLO writes, supports flush on exception, and presents HI/LO to the register-file write mux for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative radix-2 multiply/divide engine holding the architectural HI/LO
// registers of the MIPS core. One operation is in flight at a time; the core
// stalls while busy is high.
//
//   op = 00 MULTU : {hi,lo} = a * b            (unsigned)
//   op = 01 MULT  : {hi,lo} = a * b            (two's complement)
//   op = 10 DIVU  : lo = a / b, hi = a % b     (unsigned)
//   op = 11 DIV   : lo = a / b, hi = a % b     (signed, truncating)
//   Divide by zero: lo = all ones, hi = a, div_by_zero pulses with done.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        launch an operation (sampled only while idle)
//   op[1:0]      operation select (see above)
//   a, b         rs / rt operands
//   flush        abort the in-flight operation; also blocks a start while idle
//   mthi, mtlo   write wdata to HI / LO while idle
//   wdata        MTHI/MTLO data
//   busy         high while an operation is in flight
//   done         one-cycle pulse; HI/LO updated on the same edge
//   div_by_zero  pulses with done for a divide whose divisor was zero
//   hi, lo       architectural HI / LO registers
//
// Build option:
//   MULDIV_EARLY_OUT_EN  when defined, trivially-resolved operations (multiply
//                        by zero, DIVU with b > a, divide by zero) skip the
//                        iteration phase and complete two cycles after start.
//                        Results are identical with or without it.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operation context captured at start
    logic             op_div;       // 1: divide, 0: multiply
    logic             neg_q;        // negate product (mult) or quotient (div)
    logic             neg_r;        // negate remainder (div only)
    logic             dbz;          // divisor was zero
    logic [CNT_W-1:0] cnt;

    // Iteration registers.
    //   multiply: {acc,q} is the running product, q starts as the multiplier,
    //             dvs holds the multiplicand.
    //   divide:   acc is the partial remainder, q shifts the dividend out and
    //             the quotient in, dvs holds the divisor.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;

    // Conditional two's-complement negation helpers
    function automatic logic [WIDTH-1:0] neg_w(input logic n, input logic [WIDTH-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    // ---- Operand preparation (combinational, IDLE) ----
    logic                    accept;
    logic                    early;
    logic                    is_div;
    logic                    b_zero;
    logic                    sgn_eff;
    logic                    a_neg;
    logic                    b_neg;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        a_mag;
    logic [WIDTH-1:0]        b_mag;

    assign accept = (state == IDLE) && start && !flush;
    assign busy   = (state != IDLE);

    always_comb begin
        is_div  = op[1];
        b_zero  = (b == '0);
        a_s     = a;
        b_s     = b;
        // A divide by zero is treated as unsigned so the restoring loop
        // naturally yields quotient = all ones and remainder = raw a.
        sgn_eff = op[0] && !(is_div && b_zero);
        a_neg   = sgn_eff && (a_s < 0);
        b_neg   = sgn_eff && (b_s < 0);
        a_mag   = neg_w(a_neg, a);
        b_mag   = neg_w(b_neg, b);
`ifdef MULDIV_EARLY_OUT_EN
        if (is_div)
            early = b_zero || (!op[0] && (b > a));
        else
            early = (a == '0) || b_zero;
`else
        early = 1'b0;
`endif
    end

    // ---- Iteration step (combinational, RUN) ----
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;

    always_comb begin
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, dvs} : '0);
        div_shift = {acc, q[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, dvs});
        // Only used when div_ok, where the true difference is below 2^WIDTH
        div_diff  = div_shift[WIDTH-1:0] - dvs;
    end

    // ---- Sign correction (combinational, FIX) ----
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_2w(neg_q, {acc, q});
        quo_fix  = neg_w(neg_q, q);
        rem_fix  = neg_w(neg_r, acc);
    end

    // ---- Control FSM ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = early ? FIX : RUN;
            end
            RUN: begin
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(1))
                    state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- Datapath and HI/LO registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            q           <= '0;
            dvs         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_div <= is_div;
                        dbz    <= is_div && b_zero;
                        cnt    <= CNT_W'(WIDTH);
                        if (early) begin
                            // Load the final magnitudes directly; FIX just copies them.
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            acc   <= is_div ? a : '0;
                            q     <= (is_div && b_zero) ? '1 : '0;
                            dvs   <= b;
                        end else begin
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= is_div && a_neg;
                            acc   <= '0;
                            q     <= is_div ? a_mag : b_mag;
                            dvs   <= is_div ? b_mag : a_mag;
                        end
                    end else begin
                        if (mthi)
                            hi <= wdata;
                        if (mtlo)
                            lo <= wdata;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        cnt <= cnt - 1'b1;
                        if (op_div) begin
                            acc <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], div_ok};
                        end else begin
                            acc <= mul_sum[WIDTH:1];
                            q   <= {mul_sum[0], q[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (op_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        done        <= 1'b1;
                        div_by_zero <= dbz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam int W = 32;
    localparam int NV = 15;
    localparam int NR = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t tbl[NV];
    vec_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built on native SV arithmetic
    function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t                  r;
        logic [2*W-1:0]        p;
        logic signed [2*W-1:0] ex, ey, sp;
        logic signed [W-1:0]   sx, sy;
        r.op = o; r.a = x; r.b = y; r.dbz = 1'b0;
        sx = x; sy = y;
        ex = sx; ey = sy;
        case (o)
            2'b00: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                r.hi = p[2*W-1:W]; r.lo = p[W-1:0];
            end
            2'b01: begin
                sp = ex * ey;
                r.hi = sp[2*W-1:W]; r.lo = sp[W-1:0];
            end
            default: begin
                if (y == '0) begin
                    r.lo = '1; r.hi = x; r.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    r.lo = x / y; r.hi = x % y;
                end else if (x == {1'b1, {(W-1){1'b0}}} && y == '1) begin
                    r.lo = x; r.hi = '0;
                end else begin
                    r.lo = sx / sy; r.hi = sx % sy;
                end
            end
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1] && (x == '0 || y == '0)) return 2;
        if (o[1] && y == '0) return 2;
        if (o == 2'b10 && y > x) return 2;
`endif
        return W + 2;
    endfunction

    // Start driven at one negedge, dropped at the next
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // n counts negedges since the start negedge; nb counts those with busy high
    task automatic wait_done(output int n, output int nb);
        n  = 1;
        nb = busy ? 1 : 0;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end
    endtask

    task automatic check_result(input string name);
        vec_t e;
        chk({name, "_done"}, done, 1);
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            if (done) begin
                chk({name, "_hi"}, hi, e.hi);
                chk({name, "_lo"}, lo, e.lo);
                chk({name, "_dbz"}, div_by_zero, e.dbz);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n, nb;
        sb_q.push_back(v);
        launch(v.op, v.a, v.b);
        wait_done(n, nb);
        check_result(name);
        chk({name, "_lat"}, n, exp_lat(v.op, v.a, v.b));
        chk({name, "_busy_cycles"}, nb, exp_lat(v.op, v.a, v.b) - 1);
        @(negedge clk);
        chk({name, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int   n, nb, extra;
        vec_t v;

        rst = 1'b0; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst = 1'b1;

        //           op     a             b             hi            lo            dbz
        tbl[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1]  = '{2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        tbl[2]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tbl[4]  = '{2'b10, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
        tbl[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        tbl[6]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0};
        tbl[7]  = '{2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[8]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        tbl[9]  = '{2'b11, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        tbl[10] = '{2'b10, 32'd5,        32'd9,        32'd5,        32'd0,        1'b0};
        tbl[11] = '{2'b00, 32'd0,        32'h00003039, 32'd0,        32'd0,        1'b0};
        tbl[12] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        tbl[13] = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0};
        tbl[14] = '{2'b01, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};

        for (int i = 0; i < NV; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < NR; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : W'($urandom_range(1, 1000));
            v = model(ro, ra, rb);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Second start mid-run is ignored and yields no extra done
        sb_q.push_back('{2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
        launch(2'b01, 32'hFFFFFFFD, 32'd5);
        repeat (4) @(negedge clk);
        op = 2'b00; a = 32'd7; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nb);
        check_result("restart");
        extra = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("restart_extra_done", extra, 0);

        // MTHI+MTLO together, then MTLO alone
        @(negedge clk);
        wdata = 32'h11111111; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", hi, 32'h11111111);
        chk("mt_both_lo", lo, 32'h11111111);
        wdata = 32'h22222222; mtlo = 1'b1;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_hi", hi, 32'h11111111);
        chk("mtlo_lo", lo, 32'h22222222);

        // Flush mid-multiply
        launch(2'b00, 32'hFFFFFFFF, 32'd2);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        extra = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("flush_no_done", extra, 0);
        chk("flush_hi", hi, 32'h11111111);
        chk("flush_lo", lo, 32'h22222222);

        // Flush together with start in IDLE: start not accepted
        @(negedge clk);
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", busy, 0);

        // MTHI while busy is dropped; repeated in IDLE it lands
        sb_q.push_back('{2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0});
        launch(2'b00, 32'd6, 32'd7);
        wdata = 32'hA5A5A5A5; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        wait_done(n, nb);
        check_result("mthi_busy");
        @(negedge clk);
        wdata = 32'hA5A5A5A5; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_idle_hi", hi, 32'hA5A5A5A5);

        // MTHI/MTLO with an accepted start: writes dropped
        @(negedge clk);
        wdata = 32'hDEADBEEF; mthi = 1'b1; mtlo = 1'b1;
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
        sb_q.push_back('{2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0});
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("mt_start_hi", hi, 32'hA5A5A5A5);
        chk("mt_start_lo", lo, 32'd42);
        chk("mt_start_busy", busy, 1);
        wait_done(n, nb);
        check_result("mt_start");

        // Asynchronous reset mid-divide
        @(negedge clk);
        wdata = 32'h5A5A5A5A; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        launch(2'b11, 32'hFFFFFF9C, 32'd7);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        run_vec('{2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0}, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
